// File: rtl/lane2_packer_pkg.sv
// Shared definitions for the 2-bit lane packer.
// Holds the lane width and the FILL/HOLD state enumeration.
// Both are shared by the packer top and its interface.
package lane_pkg;

  localparam int LANE_W = 2;

  // FILL: assembling a word, nothing presented.
  // HOLD: a completed word is presented on the output.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/lane2_packer_if.sv
// Handshake bundle for lane2_packer.
// Input side:  in_valid, in_ready, in_data (one lane), in_last.
// Output side: out_valid, out_ready, out_data (N lanes), out_mask (N bits).
// Modport slave is the packer's view; modport master is the view of the
// producer/consumer driving the packer.
interface lane2_packer_if
  import lane_pkg::*;
#(
  parameter int N = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W*N-1:0] out_data;
  logic [N-1:0]      out_mask;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

endinterface

// File: rtl/lane2_packer_dec.sv
// Lane write-enable decoder.
// Ports: idx (lane index), we (write enable) -> lane_we (N-bit one-hot,
// all zero when we is low).
module lane2_dec #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             we,
  output logic [N-1:0]     lane_we
);

  // Compare against each lane number so an index beyond N-1 (possible when
  // N is not a power of two) selects nothing rather than indexing off the end.
  always_comb begin
    lane_we = '0;
    for (int k = 0; k < N; k++) begin
      lane_we[k] = we && (idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/lane2_packer.sv
// Packs a stream of 2-bit lane beats into N-lane words.
// Ports: clk, rst_n (async active-low), bus (lane2_packer_if.slave):
//   in_valid/in_ready/in_data/in_last  - one lane per accepted beat
//   out_valid/out_ready/out_data/out_mask - packed word, lane 0 in the LSBs,
//   out_mask marks the lanes actually written (partial words on in_last).
module lane2_packer
  import lane_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  lane2_packer_if.slave  bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LANE_W*N-1:0] data_q, data_d;
  logic [N-1:0]        mask_q, mask_d;
  logic [N-1:0]        lane_we;
  logic [IDX_W-1:0]    wr_idx;
  logic                accept;
  logic                xfer;

  // While holding, the input can only advance in the same cycle the held
  // word leaves, so readiness simply follows the consumer.
  assign bus.in_ready  = (state_q == FILL) ? 1'b1 : bus.out_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_mask  = mask_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign xfer   = bus.out_valid && bus.out_ready;

  // A beat accepted in HOLD always starts the next word at lane 0.
  assign wr_idx = (state_q == HOLD) ? '0 : idx_q;

  lane2_dec #(.N(N), .IDX_W(IDX_W)) u_dec (
    .idx     (wr_idx),
    .we      (accept),
    .lane_we (lane_we)
  );

  // Next-state logic: a departing word clears the assembly first, then any
  // accepted beat is merged on top, so the overlap case needs no special path.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mask_d  = mask_q;

    if (xfer) begin
      state_d = FILL;
      idx_d   = '0;
      data_d  = '0;
      mask_d  = '0;
    end

    for (int k = 0; k < N; k++) begin
      if (lane_we[k]) begin
        data_d[LANE_W*k +: LANE_W] = bus.in_data;
      end
    end
    mask_d = mask_d | lane_we;

    if (accept) begin
      if (bus.in_last || (wr_idx == LAST_IDX)) begin
        state_d = HOLD;
        idx_d   = '0;
      end else begin
        state_d = FILL;
        idx_d   = wr_idx + IDX_W'(1);
      end
    end
  end

  // State and word registers; reset discards any partial or held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_lane2_packer.sv
// Self-checking bench for lane2_packer (N=4): directed scenarios followed by
// randomized traffic, compared against a word-level queue model.
module tb_lane2_packer;

  localparam int N = 4;

  typedef struct packed {
    logic [2*N-1:0] data;
    logic [N-1:0]   mask;
  } word_t;

  logic clk;
  logic rst_n;

  lane2_packer_if #(.N(N)) bus ();

  lane2_packer #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int words_out;

  logic [1:0] cur_q[$];
  word_t      exp_q[$];

  // One comparison: counts it and reports a miscompare.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs the beats collected so far into a word: beat i goes to lane i.
  function automatic word_t build_word();
    word_t w;
    w = '0;
    foreach (cur_q[i]) begin
      w.data[2*i +: 2] = cur_q[i];
      w.mask[i]        = 1'b1;
    end
    return w;
  endfunction

  // Drives one cycle, checks the DUT against the model, then advances the
  // model by what the handshake rules say happens at the next edge.
  task automatic applyStimulus(input logic v, input logic [1:0] d, input logic l, input logic ordy);
    logic  holding;
    logic  acc;
    logic  xf;
    word_t w;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
    holding = (exp_q.size() != 0);
    check("out_valid", 32'(bus.out_valid), 32'(holding));
    check("in_ready", 32'(bus.in_ready), holding ? 32'(ordy) : 32'd1);
    if (holding) begin
      check("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
      check("out_mask", 32'(bus.out_mask), 32'(exp_q[0].mask));
    end
    xf  = holding && ordy;
    acc = v && (!holding || ordy);
    if (xf) begin
      w = exp_q.pop_front();
      words_out++;
    end
    if (acc) begin
      cur_q.push_back(d);
      if (l || cur_q.size() == N) begin
        exp_q.push_back(build_word());
        cur_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Explicit check of presented word against hand-derived constants.
  task automatic checkOutput(input string tag, input logic ev, input logic [7:0] ed, input logic [3:0] em);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(ev));
    if (ev) begin
      check({tag, "_data"}, 32'(bus.out_data), 32'(ed));
      check({tag, "_mask"}, 32'(bus.out_mask), 32'(em));
    end else begin
      check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    end
  endtask

  // Asynchronous reset pulse mid-cycle; everything must read cleared.
  task automatic doReset(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_rst_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_rst_mask"}, 32'(bus.out_mask), 32'd0);
    check({tag, "_rst_in_ready"}, 32'(bus.in_ready), 32'd1);
    cur_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    int w0;
    vectors     = 0;
    miscompares = 0;
    words_out   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 2'b00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    $display("[TB] reset state");
    doReset("init");

    $display("[TB] full word");
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
    checkOutput("full_early", 1'b0, 8'h00, 4'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
    checkOutput("full", 1'b1, 8'b00_11_10_01, 4'b1111);
    drain();

    $display("[TB] partial word");
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1);
    checkOutput("partial", 1'b1, 8'b00_00_10_11, 4'b0011);
    drain();

    $display("[TB] backpressure");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'($urandom()), 1'($urandom()), 1'b0);
      checkOutput("hold", 1'b1, 8'b01_01_01_01, 4'b1111);
    end
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
    checkOutput("overlap", 1'b0, 8'h00, 4'h0);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b1);
    checkOutput("overlap_word", 1'b1, 8'b00_00_11_10, 4'b0011);
    drain();

    $display("[TB] streaming");
    w0 = words_out;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 2'($urandom()), 1'b0, 1'b1);
    drain();
    check("stream_words", 32'(words_out - w0), 32'd3);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
    doReset("midword");
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
    checkOutput("after_rst", 1'b1, 8'b01_10_00_11, 4'b1111);
    drain();

    $display("[TB] last on final lane");
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1);
    checkOutput("last_full", 1'b1, 8'b00_11_10_01, 4'b1111);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
    checkOutput("last_next", 1'b0, 8'h00, 4'h0);
    drain();
    drain();
    drain();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        doReset("rand");
      end else begin
        applyStimulus(1'($urandom_range(0, 99) < 70), 2'($urandom()),
                      1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 60));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lane2_packer.md
LANE2_PACKER -- requirements
Module: lane2_packer

Interface
REQ-001 Parameter: N, default 4, number of 2-bit lanes per packed word; legal N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  in_data/in_last valid this cycle.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  2  lane value.
REQ-007 in_last  input  1  beat closes the current word (partial word allowed).
REQ-008 out_valid  output  1  packed word available.
REQ-009 out_ready  input  1  consumer takes the word this cycle.
REQ-010 out_data  output  2*N  packed word; lane k occupies bits [2k+1:2k], lane 0 = LSBs.
REQ-011 out_mask  output  N  bit k set = lane k written in this word.

Function
REQ-012 An input beat SHALL be accepted exactly when in_valid && in_ready at a rising clk edge.
REQ-013 An output word SHALL be transferred exactly when out_valid && out_ready at a rising clk edge.
REQ-014 States SHALL be FILL (assembling, out_valid=0) and HOLD (word presented, out_valid=1).
REQ-015 in_ready SHALL be 1 in FILL and equal to out_ready in HOLD (combinational, no dependence on in_valid).
REQ-016 The k-th accepted beat of a word (k = 0..N-1) SHALL be written to lane k and set out_mask[k]; lane index counts 0..N-1 and resets to 0 at each new word.
REQ-017 FILL -> HOLD on accepting the beat at lane N-1, or any beat with in_last=1; out_valid SHALL rise the cycle after that beat (latency 1 cycle).
REQ-018 Unwritten lanes of a partial word SHALL read 2'b00 with out_mask bit 0.
REQ-019 out_data and out_mask SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 HOLD with output transfer and no input beat -> FILL; data, mask and lane index cleared.
REQ-021 HOLD with output transfer and simultaneous input beat: beat SHALL become lane 0 of the new word (mask = 1); next state HOLD if in_last=1, else FILL with lane index 1.
REQ-022 Sustained in_valid=1 and out_ready=1 SHALL give one beat per cycle with no bubbles.
REQ-023 in_last on lane N-1 SHALL behave identically to a full word without in_last.
REQ-024 in_data/in_last SHALL be ignored on cycles without acceptance.

Reset
REQ-025 While rst_n=0: state FILL, lane index 0, out_valid 0, out_data all 0, out_mask all 0; in_ready reads 1.
REQ-026 Reset asserted mid-word or in HOLD SHALL discard the partial/held word; no output transfer follows reset release until a new word completes.

Structure
REQ-027 Shared package lane_pkg SHALL hold LANE_W = 2 and the FILL/HOLD state enumeration.
REQ-028 Lane index width SHALL be $clog2(N); mask and data widths derive from N only.
REQ-029 One sub-module lane2_dec SHALL convert lane index + write enable into an N-bit one-hot lane write-enable vector.

Verification (N=4)
REQ-030 Beats 01,10,11,00, out_ready=1 -> one cycle after beat 4: out_valid=1, out_data=8'b00_11_10_01, out_mask=4'b1111.
REQ-031 Beats 11,10 with in_last on beat 2 -> out_data=8'b00_00_10_11, out_mask=4'b0011.
REQ-032 Full word held with out_ready=0 for 5 cycles -> in_ready=0, out_data/out_mask unchanged; out_ready=1 with in_valid=1, in_data=10 -> word transfers and new word lane 0 = 10, mask 0001.
REQ-033 Continuous in_valid and out_ready over 12 beats -> 3 words, one per 4 cycles, in_ready never 0.
REQ-034 rst_n pulsed low after 2 beats -> out_valid=0, data/mask 0; next 4 beats form a clean word, old lanes absent.
REQ-035 in_last on 4th beat -> identical output to REQ-030.
